// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Single-entry ALU execute stage with valid/ready handshakes on
//            both sides, operand forwarding from its own result register,
//            illegal-opcode flagging, a sticky error bit and an accept counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH     = 15,
  parameter int OP_WIDTH  = 3,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  // upstream (decode) side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [IDX_WIDTH-1:0] in_rs1_idx,
  input  logic [IDX_WIDTH-1:0] in_rs2_idx,
  input  logic [IDX_WIDTH-1:0] in_rd_idx,
  input  logic [WIDTH-1:0]     in_rs1_val,
  input  logic [WIDTH-1:0]     in_rs2_val,
  input  logic                 in_use_imm,
  input  logic [WIDTH-1:0]     in_imm,
  // external combinational ALU
  output logic [OP_WIDTH-1:0]  alu_op_o,
  output logic [WIDTH-1:0]     alu_op1_o,
  output logic [WIDTH-1:0]     alu_op2_o,
  input  logic [WIDTH:0]       alu_result_i,
  // downstream (writeback) side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_result,
  output logic [IDX_WIDTH-1:0] out_rd_idx,
  output logic                 out_zero,
  output logic                 out_illegal,
  // status
  output logic                 err_sticky,
  output logic [15:0]          op_count
);

  localparam logic [OP_WIDTH-1:0] c_op_add = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] c_op_sub = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] c_op_and = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] c_op_or  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] c_op_xor = OP_WIDTH'(5);

  logic                 r_out_valid;
  logic [WIDTH:0]       r_out_result;
  logic [IDX_WIDTH-1:0] r_out_rd_idx;
  logic                 r_out_zero;
  logic                 r_out_illegal;
  logic                 r_err_sticky;
  logic [15:0]          r_op_count;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_fwd1;
  logic                 w_fwd2;
  logic [WIDTH-1:0]     w_op1;
  logic [WIDTH-1:0]     w_rs2;
  logic [WIDTH-1:0]     w_op2;
  logic [WIDTH:0]       w_next_result;

  // Ready whenever the result slot is empty or being drained; never in reset.
  assign w_in_ready = !rst && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Opcode decode: anything outside add/sub/and/or/xor is illegal.
  always_comb begin
    w_illegal = 1'b1;
    case (in_op)
      c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor: w_illegal = 1'b0;
      default:                                         w_illegal = 1'b1;
    endcase
  end

  // Operand selection: index 0 reads zero, otherwise forward the held result
  // when its destination matches (the result is still present even while it
  // drains this cycle), otherwise use the register-file value.
  always_comb begin
    w_fwd1 = r_out_valid && (r_out_rd_idx == in_rs1_idx) && (in_rs1_idx != '0);
    w_fwd2 = r_out_valid && (r_out_rd_idx == in_rs2_idx) && (in_rs2_idx != '0);

    if (in_rs1_idx == '0)
      w_op1 = '0;
    else if (w_fwd1)
      w_op1 = r_out_result[WIDTH-1:0];
    else
      w_op1 = in_rs1_val;

    if (in_rs2_idx == '0)
      w_rs2 = '0;
    else if (w_fwd2)
      w_rs2 = r_out_result[WIDTH-1:0];
    else
      w_rs2 = in_rs2_val;

    w_op2 = in_use_imm ? in_imm : w_rs2;
  end

  // Illegal opcodes produce a forced-zero result regardless of the ALU.
  assign w_next_result = w_illegal ? '0 : alu_result_i;

  // Result register, sticky error and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_rd_idx  <= '0;
      r_out_zero    <= 1'b0;
      r_out_illegal <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_op_count    <= 16'd0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= w_next_result;
      r_out_rd_idx  <= in_rd_idx;
      r_out_zero    <= (w_next_result[WIDTH-1:0] == '0);
      r_out_illegal <= w_illegal;
      r_op_count    <= r_op_count + 16'd1;
      if (w_illegal)
        r_err_sticky <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign alu_op_o    = in_op;
  assign alu_op1_o   = w_op1;
  assign alu_op2_o   = w_op2;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_rd_idx  = r_out_rd_idx;
  assign out_zero    = r_out_zero;
  assign out_illegal = r_out_illegal;
  assign err_sticky  = r_err_sticky;
  assign op_count    = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Directed self-checking bench for alu_exec_stage with a small
//            behavioural ALU attached to the stage's ALU port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

  localparam int WIDTH     = 15;
  localparam int OP_WIDTH  = 3;
  localparam int IDX_WIDTH = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_WIDTH-1:0]  in_op;
  logic [IDX_WIDTH-1:0] in_rs1_idx;
  logic [IDX_WIDTH-1:0] in_rs2_idx;
  logic [IDX_WIDTH-1:0] in_rd_idx;
  logic [WIDTH-1:0]     in_rs1_val;
  logic [WIDTH-1:0]     in_rs2_val;
  logic                 in_use_imm;
  logic [WIDTH-1:0]     in_imm;
  logic [OP_WIDTH-1:0]  alu_op_o;
  logic [WIDTH-1:0]     alu_op1_o;
  logic [WIDTH-1:0]     alu_op2_o;
  logic [WIDTH:0]       alu_result_i;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH:0]       out_result;
  logic [IDX_WIDTH-1:0] out_rd_idx;
  logic                 out_zero;
  logic                 out_illegal;
  logic                 err_sticky;
  logic [15:0]          op_count;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(
    .WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_op_o(alu_op_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
    .alu_result_i(alu_result_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd_idx(out_rd_idx), .out_zero(out_zero), .out_illegal(out_illegal),
    .err_sticky(err_sticky), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal opcodes return a non-zero pattern so the
  // stage's forced-zero behaviour is observable.
  always_comb begin
    alu_result_i = 16'h5A5A;
    case (alu_op_o)
      3'd1: alu_result_i = {1'b0, alu_op1_o} + {1'b0, alu_op2_o};
      3'd2: alu_result_i = {1'b0, alu_op1_o} - {1'b0, alu_op2_o};
      3'd3: alu_result_i = {1'b0, alu_op1_o & alu_op2_o};
      3'd4: alu_result_i = {1'b0, alu_op1_o | alu_op2_o};
      3'd5: alu_result_i = {1'b0, alu_op1_o ^ alu_op2_o};
      default: alu_result_i = 16'h5A5A;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rs1, input logic [14:0] v1,
                       input logic [2:0] rs2, input logic [14:0] v2, input logic uimm,
                       input logic [14:0] imm, input logic [2:0] rd);
    in_valid   = 1'b1;
    in_op      = op;
    in_rs1_idx = rs1;
    in_rs1_val = v1;
    in_rs2_idx = rs2;
    in_rs2_val = v2;
    in_use_imm = uimm;
    in_imm     = imm;
    in_rd_idx  = rd;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0;
    in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_use_imm = 1'b0; in_imm = '0;
    step(); step();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_rd", 32'(out_rd_idx), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // add 5 + imm 3 -> rd1
    rst = 1'b0; out_ready = 1'b1;
    drive(3'd1, 3'd3, 15'd5, 3'd0, 15'd0, 1'b1, 15'd3, 3'd1);
    #1;
    chk("first_in_ready", 32'(in_ready), 32'd1);
    chk("first_op1", 32'(alu_op1_o), 32'd5);
    chk("first_op2", 32'(alu_op2_o), 32'd3);
    step();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_result", 32'(out_result), 32'd8);
    chk("first_zero", 32'(out_zero), 32'd0);
    chk("first_rd", 32'(out_rd_idx), 32'd1);
    chk("first_count", 32'(op_count), 32'd1);

    // add 7+1 -> rd2, then sub r2 - 8 with r2 forwarded
    drive(3'd1, 3'd4, 15'd7, 3'd0, 15'd0, 1'b1, 15'd1, 3'd2);
    step();
    chk("b2b_add_result", 32'(out_result), 32'd8);
    drive(3'd2, 3'd2, 15'd99, 3'd0, 15'd0, 1'b1, 15'd8, 3'd3);
    #1;
    chk("fwd_rs1_op1", 32'(alu_op1_o), 32'd8);
    step();
    chk("b2b_sub_result", 32'(out_result), 32'd0);
    chk("b2b_sub_zero", 32'(out_zero), 32'd1);
    chk("b2b_count", 32'(op_count), 32'd3);

    // and 0x7FFF & 0x1234 -> rd4, then xor 0x00FF ^ r4 (forwarded rs2)
    drive(3'd3, 3'd5, 15'h7FFF, 3'd0, 15'd0, 1'b1, 15'h1234, 3'd4);
    step();
    chk("and_result", 32'(out_result), 32'h1234);
    drive(3'd5, 3'd6, 15'h00FF, 3'd4, 15'd0, 1'b0, 15'h7777, 3'd5);
    #1;
    chk("fwd_rs2_op2", 32'(alu_op2_o), 32'h1234);
    step();
    chk("xor_result", 32'(out_result), 32'h12CB);
    chk("xor_count", 32'(op_count), 32'd5);

    // Downstream stall for 3 cycles with a pending or 1|2 -> rd6
    out_ready = 1'b0;
    drive(3'd4, 3'd7, 15'd1, 3'd0, 15'd0, 1'b1, 15'd2, 3'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("stall_result", 32'(out_result), 32'h12CB);
      chk("stall_count", 32'(op_count), 32'd5);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("drain_result", 32'(out_result), 32'd3);
    chk("drain_rd", 32'(out_rd_idx), 32'd6);
    chk("drain_valid", 32'(out_valid), 32'd1);
    chk("drain_count", 32'(op_count), 32'd6);

    // Borrow: 1 - 2 -> 0xFFFF in WIDTH+1 bits
    drive(3'd2, 3'd1, 15'd1, 3'd0, 15'd0, 1'b1, 15'd2, 3'd7);
    step();
    chk("borrow_result", 32'(out_result), 32'hFFFF);
    chk("borrow_zero", 32'(out_zero), 32'd0);
    // Carry: 0x7FFF + 1 -> 0x8000, low bits zero
    drive(3'd1, 3'd2, 15'h7FFF, 3'd0, 15'd0, 1'b1, 15'd1, 3'd7);
    step();
    chk("carry_result", 32'(out_result), 32'h8000);
    chk("carry_zero", 32'(out_zero), 32'd1);

    // Illegal opcode 111, then a legal add keeps the sticky error
    drive(3'd7, 3'd1, 15'd3, 3'd0, 15'd0, 1'b1, 15'd4, 3'd1);
    step();
    chk("ill_result", 32'(out_result), 32'd0);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_err", 32'(err_sticky), 32'd1);
    chk("ill_count", 32'(op_count), 32'd9);
    drive(3'd1, 3'd2, 15'd2, 3'd0, 15'd0, 1'b1, 15'd2, 3'd2);
    step();
    chk("post_ill_result", 32'(out_result), 32'd4);
    chk("post_ill_flag", 32'(out_illegal), 32'd0);
    chk("post_ill_err", 32'(err_sticky), 32'd1);

    // Opcode 000 is illegal too
    drive(3'd0, 3'd1, 15'd6, 3'd0, 15'd0, 1'b1, 15'd6, 3'd3);
    step();
    chk("op0_flag", 32'(out_illegal), 32'd1);
    chk("op0_result", 32'(out_result), 32'd0);

    // Drain without a new accept: valid drops, data holds
    in_valid = 1'b0;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_result", 32'(out_result), 32'd0);
    chk("idle_rd", 32'(out_rd_idx), 32'd3);
    chk("idle_count", 32'(op_count), 32'd11);

    // rd=0 result still flows; index 0 reads zero even with a match
    drive(3'd1, 3'd1, 15'd10, 3'd0, 15'd0, 1'b1, 15'd5, 3'd0);
    step();
    chk("rd0_valid", 32'(out_valid), 32'd1);
    chk("rd0_result", 32'(out_result), 32'd15);
    chk("rd0_rd", 32'(out_rd_idx), 32'd0);
    drive(3'd4, 3'd0, 15'h55, 3'd0, 15'h66, 1'b0, 15'd0, 3'd1);
    #1;
    chk("idx0_op1", 32'(alu_op1_o), 32'd0);
    chk("idx0_op2", 32'(alu_op2_o), 32'd0);

    // Reset while holding a stalled result
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_stall_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_count", 32'(op_count), 32'd0);
    chk("rst_stall_err", 32'(err_sticky), 32'd0);

    // Counter wrap: 65535 accepts then one more
    rst = 1'b0; out_ready = 1'b1;
    drive(3'd1, 3'd1, 15'd1, 3'd0, 15'd0, 1'b1, 15'd1, 3'd1);
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", 32'(op_count), 32'hFFFF);
    step();
    chk("cnt_wrap", 32'(op_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
